psk_signal_narrow: RTL

- Receive-side counterpart of the TX signal-extend stage.
- Takes wide signed ADC samples of a BPSK/QPSK signal and produces narrowed, rounded and saturated samples for the demodulator.
- A block AGC selects a power-of-two gain from the peak magnitude measured over fixed windows.
- Passes the BPSK/QPSK mode flag through, aligned with the output data.

---
 rtl/psk_rx_pkg.sv | 26 ++
 rtl/psk_rx_agc_ctrl.sv | 105 ++++++++++
 rtl/psk_signal_narrow.sv | 111 +++++++++++
 3 files changed

// File: rtl/psk_rx_pkg.sv
// Shared constants and types for the PSK receive narrowing path.
package psk_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_UPDATE
    } agc_st_e;

    function automatic int base_shift(int iw, int ow);
        return iw - ow;
    endfunction

    function automatic int gain_w(int mg);
        return (mg < 1) ? 1 : $clog2(mg + 1);
    endfunction

    function automatic int sat_hi(int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int sat_lo(int ow);
        return -(1 << (ow - 1));
    endfunction

endpackage

// File: rtl/psk_rx_agc_ctrl.sv
// Block AGC: windowed peak tracking and power-of-two gain selection.
module psk_rx_agc_ctrl
    import psk_rx_pkg::*;
#(
    parameter int I_WIDTH  = 16,
    parameter int WIN_LOG2 = 10,
    parameter int MAX_GAIN = 4,
    parameter int GW       = gain_w(MAX_GAIN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic signed [I_WIDTH-1:0] i_sample,
    input  logic                      i_is_bpsk,
    input  logic                      i_agc_en,
    output logic [GW-1:0]             o_gain
);

    localparam int PW = I_WIDTH - 1;
    localparam int CW = WIN_LOG2;
    localparam int XW = I_WIDTH + MAX_GAIN + 1;
    localparam logic signed [I_WIDTH-1:0] X_MIN =
        {1'b1, {(I_WIDTH-1){1'b0}}};
    localparam logic [XW-1:0] TH_HI = XW'(1) << (I_WIDTH - 1);
    localparam logic [XW-1:0] TH_LO = XW'(1) << (I_WIDTH - 2);

    agc_st_e         r_state;
    logic [PW-1:0]   r_peak;
    logic [CW-1:0]   r_count;
    logic [GW-1:0]   r_g;
    logic            r_last_bpsk;

    logic [PW-1:0]   w_mag;
    logic [PW-1:0]   w_peak_max;
    logic [XW-1:0]   w_shl;
    logic            w_dn;
    logic            w_up;

    // most-negative input has no positive twin; clamp its magnitude
    always_comb begin
        w_mag = PW'(i_sample);
        if (i_sample == X_MIN)
            w_mag = '1;
        else if (i_sample[I_WIDTH-1])
            w_mag = PW'(-i_sample);
    end

    assign w_peak_max = (w_mag > r_peak) ? w_mag : r_peak;
    assign w_shl = XW'(r_peak) << r_g;
    assign w_dn  = (w_shl >= TH_HI) && (r_g != '0);
    assign w_up  = ((w_shl << 1) < TH_LO) && (r_g < GW'(MAX_GAIN));
    assign o_gain = r_g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_peak      <= '0;
            r_count     <= '0;
            r_g         <= '0;
            r_last_bpsk <= 1'b0;
        end else begin
            if (i_valid)
                r_last_bpsk <= i_is_bpsk;
            if (!i_agc_en) begin
                r_state <= ST_IDLE;
                r_g     <= '0;
                r_peak  <= '0;
                r_count <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_TRACK;
                        r_g     <= '0;
                        r_peak  <= '0;
                        r_count <= '0;
                    end
                    ST_TRACK: begin
                        if (i_valid) begin
                            if (i_is_bpsk != r_last_bpsk) begin
                                r_count <= CW'(1);
                                r_peak  <= w_mag;
                            end else begin
                                r_count <= r_count + CW'(1);
                                r_peak  <= w_peak_max;
                                if (&r_count)
                                    r_state <= ST_UPDATE;
                            end
                        end
                    end
                    ST_UPDATE: begin
                        if (w_dn)
                            r_g <= r_g - GW'(1);
                        else if (w_up)
                            r_g <= r_g + GW'(1);
                        r_peak  <= i_valid ? w_mag : '0;
                        r_count <= i_valid ? CW'(1) : '0;
                        r_state <= ST_TRACK;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/psk_signal_narrow.sv
// Receive narrowing: round, shift by BASE-g and saturate wide ADC samples.
module psk_signal_narrow
    import psk_rx_pkg::*;
#(
    parameter int I_WIDTH  = 16,
    parameter int O_WIDTH  = 12,
    parameter int WIN_LOG2 = 10,
    parameter int MAX_GAIN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [I_WIDTH-1:0]    ADC_sample,
    input  logic                         in_valid,
    input  logic                         is_bpsk,
    input  logic                         agc_en,
    output logic signed [O_WIDTH-1:0]    PSK_signal,
    output logic                         out_valid,
    output logic                         is_bpsk_out,
    output logic [gain_w(MAX_GAIN)-1:0]  gain_out,
    output logic                         sat_flag
);

    localparam int BASE = base_shift(I_WIDTH, O_WIDTH);
    localparam int GW   = gain_w(MAX_GAIN);
    localparam int SW   = $clog2(I_WIDTH + 1);
    localparam int XW   = I_WIDTH + 1;
    localparam logic signed [XW-1:0] Y_HI = XW'(sat_hi(O_WIDTH));
    localparam logic signed [XW-1:0] Y_LO = XW'(sat_lo(O_WIDTH));

    logic signed [I_WIDTH-1:0] r_x;
    logic                      r_bpsk1;
    logic [GW-1:0]             r_g1;
    logic                      r_v1;

    logic [GW-1:0]             w_g;
    logic [SW-1:0]             w_s;
    logic signed [XW-1:0]      w_ext;
    logic signed [XW-1:0]      w_rnd;
    logic signed [XW-1:0]      w_sum;
    logic signed [XW-1:0]      w_y;
    logic                      w_hi;
    logic                      w_lo;
    logic [O_WIDTH-1:0]        w_out;

    psk_rx_agc_ctrl #(
        .I_WIDTH  (I_WIDTH),
        .WIN_LOG2 (WIN_LOG2),
        .MAX_GAIN (MAX_GAIN),
        .GW       (GW)
    ) u_agc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (in_valid),
        .i_sample  (ADC_sample),
        .i_is_bpsk (is_bpsk),
        .i_agc_en  (agc_en),
        .o_gain    (w_g)
    );

    assign gain_out = w_g;

    // one extra bit of headroom keeps the half-LSB add from wrapping
    assign w_s   = SW'(BASE) - SW'(r_g1);
    assign w_ext = {r_x[I_WIDTH-1], r_x};
    assign w_rnd = (w_s == '0) ? '0 : (XW'(1) << (w_s - SW'(1)));
    assign w_sum = w_ext + w_rnd;
    assign w_y   = w_sum >>> w_s;
    assign w_hi  = (w_y > Y_HI);
    assign w_lo  = (w_y < Y_LO);

    always_comb begin
        w_out = w_y[O_WIDTH-1:0];
        if (w_hi)
            w_out = Y_HI[O_WIDTH-1:0];
        else if (w_lo)
            w_out = Y_LO[O_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_bpsk1 <= 1'b0;
            r_g1    <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_x     <= ADC_sample;
                r_bpsk1 <= is_bpsk;
                r_g1    <= w_g;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PSK_signal  <= '0;
            out_valid   <= 1'b0;
            is_bpsk_out <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                PSK_signal  <= w_out;
                is_bpsk_out <= r_bpsk1;
                sat_flag    <= w_hi | w_lo;
            end
        end
    end

endmodule
